// File: rtl/framebuf_pkg.sv
// Shared widths and FSM encoding for the LED frame-buffer scan reader.
package framebuf_pkg;
    localparam int FB_ADDR_W = 13;
    localparam int FB_DATA_W = 16;
    localparam int FB_DEPTH  = 8192;
    localparam int ROW_W     = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SHIFT,
        ST_LATCH
    } fb_state_t;

    typedef struct packed {
        logic                 cs;
        logic [FB_ADDR_W-1:0] addr;
    } fb_req_t;
endpackage

// File: rtl/led_shift_tx.sv
// Serialises one 16-bit word MSB first: sclk low then high for SCLK_HALF clk
// cycles per bit, shifting on the falling edge; done marks the last cycle.
module led_shift_tx
    import framebuf_pkg::*;
#(
    parameter int SCLK_HALF = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [FB_DATA_W-1:0] data,
    output logic                 sclk,
    output logic                 sdo,
    output logic                 done
);
    localparam int PH_W = $clog2(2 * SCLK_HALF);

    logic [FB_DATA_W-1:0] shreg;
    logic [3:0]           bit_cnt;
    logic [PH_W-1:0]      phase;
    logic                 active;
    logic                 ph_last;

    assign ph_last = (phase == PH_W'(2 * SCLK_HALF - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            phase   <= '0;
            active  <= 1'b0;
        end else if (load) begin
            shreg   <= data;
            bit_cnt <= '0;
            phase   <= '0;
            active  <= 1'b1;
        end else if (active) begin
            if (ph_last) begin
                // End of the high half is the falling edge: advance to next bit.
                phase   <= '0;
                shreg   <= {shreg[FB_DATA_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd15)
                    active <= 1'b0;
            end else begin
                phase <= phase + PH_W'(1);
            end
        end
    end

    assign sclk = active && (phase >= PH_W'(SCLK_HALF));
    assign sdo  = shreg[FB_DATA_W-1];
    assign done = active && ph_last && (bit_cnt == 4'd15);
endmodule

// File: rtl/framebuf_scan_reader.sv
// Scans the frame buffer word by word, shifts each word to the LED driver and
// latches every completed row; a frame in progress always runs to its end.
module framebuf_scan_reader
    import framebuf_pkg::*;
#(
    parameter int DEPTH        = FB_DEPTH,
    parameter int ROW_WORDS    = 64,
    parameter int SCLK_HALF    = 2,
    parameter int LATCH_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic [FB_ADDR_W-1:0] address,
    output logic                 chipselect,
    output logic                 write,
    output logic [1:0]           byteenable,
    input  logic [FB_DATA_W-1:0] readdata,
    output logic                 sclk,
    output logic                 sdo,
    output logic                 latch,
    output logic                 blank,
    output logic [ROW_W-1:0]     row_sel,
    output logic                 frame_start,
    output logic                 busy
);
    localparam int ROWS  = DEPTH / ROW_WORDS;
    localparam int COL_W = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
    localparam int LAT_W = $clog2(LATCH_CYCLES + 1);

    fb_state_t            state, state_nxt;
    fb_req_t              req;
    logic [FB_ADDR_W-1:0] ptr;
    logic [ROW_W-1:0]     row;
    logic [COL_W-1:0]     col;
    logic [LAT_W-1:0]     lat_cnt;
    logic                 ld;
    logic                 tx_done;
    logic                 row_last;
    logic                 lat_last;

    assign row_last = (col == COL_W'(ROW_WORDS - 1));
    assign lat_last = (lat_cnt == LAT_W'(LATCH_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        req.cs    = 1'b0;
        req.addr  = ptr;
        ld        = 1'b0;
        case (state)
            ST_IDLE:  if (enable) state_nxt = ST_FETCH;
            ST_FETCH: begin
                req.cs    = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Read data arrives one cycle after the strobe.
                ld        = 1'b1;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: if (tx_done) state_nxt = row_last ? ST_LATCH : ST_FETCH;
            ST_LATCH: begin
                // Enable is only honoured once the frame has wrapped.
                if (lat_last)
                    state_nxt = (ptr == '0 && !enable) ? ST_IDLE : ST_FETCH;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            row     <= '0;
            col     <= '0;
            row_sel <= '0;
            lat_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    ptr <= '0;
                    row <= '0;
                    col <= '0;
                end
                ST_SHIFT: begin
                    if (tx_done) begin
                        ptr <= (ptr == FB_ADDR_W'(DEPTH - 1)) ? '0 : ptr + FB_ADDR_W'(1);
                        col <= row_last ? '0 : col + COL_W'(1);
                        if (row_last) begin
                            row_sel <= row;
                            row     <= (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
                            lat_cnt <= '0;
                        end
                    end
                end
                ST_LATCH: lat_cnt <= lat_cnt + LAT_W'(1);
                default: ;
            endcase
        end
    end

    led_shift_tx #(.SCLK_HALF(SCLK_HALF)) u_tx (
        .clk   (clk),
        .reset (reset),
        .load  (ld),
        .data  (readdata),
        .sclk  (sclk),
        .sdo   (sdo),
        .done  (tx_done)
    );

    assign address     = req.addr;
    assign chipselect  = req.cs;
    assign frame_start = req.cs && (ptr == '0);
    assign busy        = (state != ST_IDLE);
    assign latch       = (state == ST_LATCH);
    assign blank       = (state == ST_IDLE) || (state == ST_LATCH);
    assign write       = 1'b0;
    assign byteenable  = 2'b11;
endmodule

// File: tb/tb_framebuf_scan_reader.sv
// Directed bench for the scan reader on a reduced 256-word, 4-row frame.
module tb_framebuf_scan_reader;
    localparam int DEPTH        = 256;
    localparam int ROW_WORDS    = 64;
    localparam int SCLK_HALF    = 2;
    localparam int LATCH_CYCLES = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [12:0] address;
    logic        chipselect, write;
    logic [1:0]  byteenable;
    logic [15:0] readdata = 16'h0;
    logic        sclk, sdo, latch, blank;
    logic [6:0]  row_sel;
    logic        frame_start, busy;

    int total = 0;
    int bad = 0;

    framebuf_scan_reader #(
        .DEPTH(DEPTH), .ROW_WORDS(ROW_WORDS), .SCLK_HALF(SCLK_HALF), .LATCH_CYCLES(LATCH_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .address(address), .chipselect(chipselect),
        .write(write), .byteenable(byteenable), .readdata(readdata), .sclk(sclk), .sdo(sdo),
        .latch(latch), .blank(blank), .row_sel(row_sel), .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:DEPTH-1];
    initial begin
        mem[0] = 16'hA5F0;
        for (int i = 1; i < DEPTH; i++) mem[i] = 16'(i * 16'h0123) ^ 16'h5A3C;
    end

    always @(posedge clk) if (chipselect) readdata <= mem[address[7:0]];

    // Continuous checks and bookkeeping, sampled just before each active edge.
    bit          mon_on = 1'b0;
    int          cyc = 0;
    logic        prev_cs = 1'b0, prev_latch = 1'b0;
    logic [12:0] last_cs_addr = 13'd0, max_addr = 13'd0;
    logic [6:0]  last_latch_row = 7'd0;
    int          idle_cycles = 0, latch_rises = 0;

    always @(posedge clk) begin
        cyc++;
        if (mon_on) begin
            total++;
            if (write !== 1'b0 || byteenable !== 2'b11) begin
                bad++;
                $display("FAIL const_outputs write=%b byteenable=%b required 0/11", write, byteenable);
            end
            total++;
            if (chipselect && prev_cs) begin
                bad++;
                $display("FAIL cs_back_to_back address=%0d cs high two cycles, required single", address);
            end
            total++;
            if (frame_start !== (chipselect && address == 13'd0)) begin
                bad++;
                $display("FAIL frame_start_pulse got=%b cs=%b address=%0d", frame_start, chipselect, address);
            end
            total++;
            if ((chipselect || latch || !busy) && sclk !== 1'b0) begin
                bad++;
                $display("FAIL sclk_idle got sclk=%b outside shift, required 0", sclk);
            end
            if (chipselect) begin
                last_cs_addr = address;
                if (address > max_addr) max_addr = address;
            end
            if (latch && !prev_latch) begin
                last_latch_row = row_sel;
                latch_rises++;
            end
            if (!busy) idle_cycles++;
            prev_cs    = chipselect;
            prev_latch = latch;
        end
    end

    task automatic capture_word(output logic [15:0] bits, output int first_rise, output int last_rise,
                                output int min_gap, output int max_gap, output bit to);
        int   n;
        logic prev;
        n = 0; prev = sclk; bits = 16'h0;
        first_rise = 0; last_rise = 0; min_gap = 1000; max_gap = 0;
        for (int i = 0; i < 1000 && n < 16; i++) begin
            @(negedge clk);
            if (sclk && !prev) begin
                bits = {bits[14:0], sdo};
                if (n == 0) first_rise = cyc;
                else begin
                    if (cyc - last_rise < min_gap) min_gap = cyc - last_rise;
                    if (cyc - last_rise > max_gap) max_gap = cyc - last_rise;
                end
                last_rise = cyc;
                n++;
            end
            prev = sclk;
        end
        to = (n < 16);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0;
        repeat (3) @(negedge clk);
        mon_on = 1'b1;
        total++;
        if ({address, chipselect, sclk, sdo, latch, blank, row_sel, frame_start, busy} !==
            {13'd0, 5'b00001, 7'd0, 2'b00}) begin
            bad++;
            $display("FAIL reset_state addr=%0d cs=%b sclk=%b sdo=%b latch=%b blank=%b row=%0d fs=%b busy=%b",
                     address, chipselect, sclk, sdo, latch, blank, row_sel, frame_start, busy);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b0 || chipselect !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_enable busy=%b cs=%b required 0/0", busy, chipselect);
        end
    endtask

    task automatic test_first_word();
        logic [15:0] b;
        int f0, l0, f1, l1, mn, mx, fetch_cyc;
        bit to;
        enable = 1'b1;
        @(negedge clk);
        fetch_cyc = cyc;
        total++;
        if ({chipselect, address, frame_start, busy} !== {1'b1, 13'd0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL first_fetch cs=%b addr=%0d fs=%b busy=%b required 1/0/1/1",
                     chipselect, address, frame_start, busy);
        end
        capture_word(b, f0, l0, mn, mx, to);
        total++;
        if (to) begin bad++; $display("FAIL word0_timeout got fewer than 16 sclk edges"); end
        total++;
        if (b !== 16'hA5F0) begin bad++; $display("FAIL word0_bits got=%h required=a5f0", b); end
        total++;
        if (mn != 4 || mx != 4) begin bad++; $display("FAIL bit_period got min=%0d max=%0d required 4", mn, mx); end
        total++;
        if (f0 - fetch_cyc != 4) begin bad++; $display("FAIL first_rise_latency got=%0d required 4", f0 - fetch_cyc); end
        capture_word(b, f1, l1, mn, mx, to);
        total++;
        if (to || b !== mem[1]) begin bad++; $display("FAIL word1_bits got=%h required=%h", b, mem[1]); end
        total++;
        if (f1 - l0 != 6) begin bad++; $display("FAIL word_gap rise-to-rise got=%0d required 6", f1 - l0); end
    endtask

    task automatic test_row_latch();
        bit to;
        int n;
        bit blank_ok;
        to = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (latch) begin to = 1'b0; break; end
        end
        total++;
        if (to) begin bad++; $display("FAIL latch_timeout no latch within budget"); end
        total++;
        if (last_cs_addr !== 13'd63 || row_sel !== 7'd0) begin
            bad++;
            $display("FAIL row0_latch last_addr=%0d row_sel=%0d required 63/0", last_cs_addr, row_sel);
        end
        n = 1; blank_ok = (blank === 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!latch) break;
            n++;
            if (blank !== 1'b1) blank_ok = 1'b0;
        end
        total++;
        if (n != 4) begin bad++; $display("FAIL latch_width got=%0d required 4", n); end
        total++;
        if (!blank_ok) begin bad++; $display("FAIL blank_in_latch blank dropped during latch, required 1"); end
        total++;
        if ({chipselect, address, blank} !== {1'b1, 13'd64, 1'b0}) begin
            bad++;
            $display("FAIL after_latch_fetch cs=%b addr=%0d blank=%b required 1/64/0", chipselect, address, blank);
        end
    endtask

    int idle0;

    task automatic test_enable_glitch();
        bit to;
        to = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (chipselect && address == 13'd150) begin to = 1'b0; break; end
        end
        total++;
        if (to) begin bad++; $display("FAIL glitch_timeout address 150 not reached"); end
        idle0 = idle_cycles;
        enable = 1'b0;
        repeat (20) @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic test_frame_wrap();
        bit to;
        to = 1'b1;
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            if (chipselect && address == 13'd0) begin to = 1'b0; break; end
        end
        total++;
        if (to) begin bad++; $display("FAIL wrap_timeout address 0 not refetched"); end
        total++;
        if (frame_start !== 1'b1 || last_cs_addr !== 13'd255) begin
            bad++;
            $display("FAIL wrap_fetch fs=%b prev_addr=%0d required 1/255", frame_start, last_cs_addr);
        end
        total++;
        if (last_latch_row !== 7'd3 || row_sel !== 7'd3) begin
            bad++;
            $display("FAIL last_row latched=%0d row_sel=%0d required 3", last_latch_row, row_sel);
        end
        total++;
        if (max_addr !== 13'd255) begin bad++; $display("FAIL max_address got=%0d required 255", max_addr); end
        total++;
        if (idle_cycles != idle0) begin
            bad++;
            $display("FAIL glitch_no_effect idle cycles got=%0d required 0", idle_cycles - idle0);
        end
    endtask

    task automatic test_enable_drop();
        bit to;
        int lr0;
        to = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (chipselect && address == 13'd100) begin to = 1'b0; break; end
        end
        enable = 1'b0;
        lr0 = latch_rises;
        for (int i = 0; i < 30000 && !to; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (i == 29999) to = 1'b1;
        end
        total++;
        if (to) begin bad++; $display("FAIL drop_timeout busy never fell"); end
        total++;
        if (last_cs_addr !== 13'd255 || last_latch_row !== 7'd3 || latch_rises - lr0 != 3) begin
            bad++;
            $display("FAIL drop_completes last_addr=%0d last_row=%0d latches=%0d required 255/3/3",
                     last_cs_addr, last_latch_row, latch_rises - lr0);
        end
        repeat (10) @(negedge clk);
        total++;
        if ({busy, chipselect, blank, sclk} !== 4'b0010) begin
            bad++;
            $display("FAIL stays_idle busy=%b cs=%b blank=%b sclk=%b required 0/0/1/0", busy, chipselect, blank, sclk);
        end
    endtask

    task automatic test_reset_mid_shift();
        bit to;
        enable = 1'b1;
        @(negedge clk);
        total++;
        if ({chipselect, address, frame_start} !== {1'b1, 13'd0, 1'b1}) begin
            bad++;
            $display("FAIL restart_fetch cs=%b addr=%0d fs=%b required 1/0/1", chipselect, address, frame_start);
        end
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sclk) begin to = 1'b0; break; end
        end
        total++;
        if (to) begin bad++; $display("FAIL restart_shift_timeout sclk never high"); end
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if ({address, chipselect, sclk, sdo, latch, blank, row_sel, frame_start, busy} !==
                {13'd0, 5'b00001, 7'd0, 2'b00}) begin
                bad++;
                $display("FAIL mid_shift_reset cyc=%0d addr=%0d cs=%b sclk=%b sdo=%b latch=%b blank=%b row=%0d fs=%b busy=%b",
                         k, address, chipselect, sclk, sdo, latch, blank, row_sel, frame_start, busy);
            end
        end
        reset = 1'b0; enable = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle busy=%b required 0", busy); end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_row_latch();
        test_enable_glitch();
        test_frame_wrap();
        test_enable_drop();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
